// File: rtl/decoder_grant_arbiter_if.sv
// rtl/decoder_grant_arbiter_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface decoder_grant_arbiter_if;
  logic        arb_en;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        grant_valid;
  logic        timeout_pulse;

  modport master (
    input  arb_en, req,
    output grant, grant_id, grant_valid, timeout_pulse
  );

  modport slave (
    output arb_en, req,
    input  grant, grant_id, grant_valid, timeout_pulse
  );
endinterface

// File: rtl/decoder_grant_arbiter.sv
// rtl/decoder_grant_arbiter.sv - 16-way round-robin grant arbiter with one-cycle handover gap
// Optional forced-revoke hold limit compiled in with ARB_TIMEOUT_EN.
module decoder_grant_arbiter #(
  parameter int MAX_HOLD = 255,
  parameter int HOLD_W   = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  decoder_grant_arbiter_if.master bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_param
    $error("decoder_grant_arbiter: illegal MAX_HOLD/HOLD_W combination");
  end

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t      state, state_d;
  logic [15:0] grant_q, grant_d;
  logic [3:0]  id_q, id_d;
  logic        valid_q, valid_d;
  logic [3:0]  last_id, last_d;
  logic [3:0]  sel, cand;
  logic        found;

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic              pulse_q, pulse_d;
`endif

  // Search starts just past the previous owner, so it ends up lowest priority.
  always_comb begin
    found = 1'b0;
    sel   = 4'h0;
    cand  = 4'h0;
    for (int i = 1; i <= 16; i++) begin
      cand = last_id + 4'(i);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant_q;
    id_d    = id_q;
    valid_d = valid_q;
    last_d  = last_id;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_cnt;
    pulse_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.arb_en && found) begin
          state_d = BUSY;
          grant_d = 16'h0001 << sel;
          id_d    = sel;
          valid_d = 1'b1;
          last_d  = sel;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      BUSY: begin
        if (!bus.req[id_q]) begin
          state_d = GAP;
          grant_d = 16'h0000;
          id_d    = 4'h0;
          valid_d = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        // A release on the same edge wins over expiry, so no pulse then.
        else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          state_d = GAP;
          grant_d = 16'h0000;
          id_d    = 4'h0;
          valid_d = 1'b0;
          pulse_d = 1'b1;
        end else begin
          hold_d = hold_cnt + HOLD_W'(1);
        end
`endif
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= 16'h0000;
      id_q    <= 4'h0;
      valid_q <= 1'b0;
      last_id <= 4'hF;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
      pulse_q  <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      last_id <= last_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= hold_d;
      pulse_q  <= pulse_d;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = id_q;
  assign bus.grant_valid = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_pulse = pulse_q;
`else
  assign bus.timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// tb/tb_decoder_grant_arbiter.sv - scoreboard bench for decoder_grant_arbiter (honours ARB_TIMEOUT_EN)
module tb_decoder_grant_arbiter;

  localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;

  decoder_grant_arbiter_if bus();

  decoder_grant_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] g;
    logic [3:0]  id;
    logic        v;
    logic        p;
  } exp_t;

  exp_t expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the resource, how long it has been visible,
  // and whether the mandatory empty handover cycle is pending.
  initial begin
    int   owner;
    int   last;
    int   held;
    bit   in_gap;
    bit   pulse;
    exp_t e;
    owner = -1; last = 15; held = 0; in_gap = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        owner = -1; last = 15; held = 0; in_gap = 1'b0;
        expq.delete();
      end else begin
        pulse = 1'b0;
        if (in_gap) begin
          in_gap = 1'b0;
        end else if (owner >= 0) begin
          if (!bus.req[owner]) begin
            owner = -1; in_gap = 1'b1;
          end else if (TIMEOUT_ON && held == MAX_HOLD) begin
            owner = -1; in_gap = 1'b1; pulse = 1'b1;
          end else begin
            held++;
          end
        end else if (bus.arb_en && bus.req != 16'h0) begin
          for (int k = 1; k <= 16; k++) begin
            if (owner < 0 && bus.req[(last + k) % 16]) owner = (last + k) % 16;
          end
          last = owner;
          held = 1;
        end
        e.g  = (owner >= 0) ? (16'h0001 << owner) : 16'h0000;
        e.id = (owner >= 0) ? 4'(owner) : 4'h0;
        e.v  = (owner >= 0);
        e.p  = pulse;
        expq.push_back(e);
      end
    end
  end

  // Monitor: compares DUT outputs against the model, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_outputs", {bus.grant, bus.grant_id, bus.grant_valid, bus.timeout_pulse}, 0);
      end else if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("sb_grant", bus.grant, e.g);
        chk("sb_grant_id", bus.grant_id, e.id);
        chk("sb_grant_valid", bus.grant_valid, e.v);
        chk("sb_timeout_pulse", bus.timeout_pulse, e.p);
        chk("onehot", ($countones(bus.grant) <= 1), 1);
      end
    end
  end

  initial begin
    int n;
    int pulses;
    int id;
    rst_n = 1'b1;
    bus.req = 16'h0;
    bus.arb_en = 1'b0;
    #1 rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;

    // Single request
    bus.arb_en = 1'b1;
    bus.req = 16'h0001;
    cyc(1);
    chk("single_grant", bus.grant, 16'h0001);
    chk("single_id", bus.grant_id, 0);
    cyc(3);
    bus.req = 16'h0;
    cyc(1);
    chk("single_gap", bus.grant, 0);
    cyc(1);
    chk("single_idle", bus.grant, 0);

    // Wrap
    bus.req = 16'h4000;
    cyc(1);
    chk("wrap_setup_id", bus.grant_id, 14);
    bus.req = 16'h0;
    cyc(2);
    bus.req = 16'h4001;
    cyc(1);
    chk("wrap_id0", bus.grant_id, 0);
    bus.req = 16'h0;
    cyc(2);
    bus.req = 16'h4001;
    cyc(1);
    chk("wrap_id14", bus.grant_id, 14);
    bus.req = 16'h0;
    cyc(2);

    // arb_en gating
    bus.arb_en = 1'b0;
    bus.req = 16'h0100;
    cyc(2);
    chk("arb_en_block", bus.grant, 0);
    bus.arb_en = 1'b1;
    cyc(1);
    chk("arb_en_id", bus.grant_id, 8);
    bus.arb_en = 1'b0;
    cyc(3);
    chk("arb_en_hold", bus.grant, 16'h0100);
    bus.req = 16'h0;
    cyc(1);
    chk("arb_en_release", bus.grant, 0);
    cyc(1);
    bus.arb_en = 1'b1;

    // Hold limit
    bus.req = 16'h0004;
    cyc(1);
    chk("hold_grant", bus.grant, 16'h0004);
`ifdef ARB_TIMEOUT_EN
    n = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (bus.grant == 16'h0004) n++;
      else break;
    end
    chk("timeout_len", n, MAX_HOLD);
    chk("timeout_pulse", bus.timeout_pulse, 1);
    chk("timeout_gap", bus.grant, 0);
    cyc(1);
    chk("timeout_pulse_end", bus.timeout_pulse, 0);
    cyc(1);
    chk("timeout_regrant", bus.grant, 16'h0004);
`else
    n = 0;
    pulses = 0;
    repeat (110) begin
      cyc(1);
      if (bus.grant == 16'h0004) n++;
      if (bus.timeout_pulse) pulses++;
    end
    chk("no_timeout_len", n, 110);
    chk("no_timeout_pulses", pulses, 0);
`endif
    bus.req = 16'h0;
    cyc(2);

    // Asynchronous reset mid-grant
    bus.req = 16'h0010;
    cyc(1);
    chk("rst_pre_grant", bus.grant, 16'h0010);
    rst_n = 1'b0;
    #1;
    chk("rst_immediate", {bus.grant, bus.grant_valid, bus.timeout_pulse}, 0);
    bus.req = 16'h0001;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_first_id", bus.grant_id, 0);
    chk("rst_first_grant", bus.grant, 16'h0001);
    bus.req = 16'h0;
    cyc(2);

    // Fairness from a fresh reset
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      bus.req = 16'hFFFF;
      cyc(1);
      id = int'(bus.grant_id);
      chk("fair_id", id, k % 16);
      cyc(1);
      bus.req = 16'hFFFF & ~(16'h0001 << id);
      cyc(1);
      chk("fair_gap", bus.grant, 0);
      cyc(1);
    end
    bus.req = 16'h0;
    cyc(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 16'($urandom) & 16'($urandom) & 16'($urandom);
      bus.arb_en = ($urandom_range(0, 7) != 0);
      cyc(1);
    end
    bus.req = 16'h0;
    cyc(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
